data_memory_banked: RTL and testbench
=====================================

# data_memory_banked

Parametrised, banked, multi-port data memory for the multicore matrix-multiplication array: N_PORTS cores share one word-addressed store split into N_BANKS interleaved single-port banks. Each port uses a req/gnt handshake. A per-bank arbiter grants at most one port per bank per cycle, and reads return registered data one cycle after grant. It replaces the fixed 10-port, combinational-read, unarbitrated memory, adding conflict arbitration, out-of-range detection and a parametrised port count.

## Interface
- N_PORTS, 10: number of core ports (≥2)
- DATA_W, 16: word width
- ADDR_W, 16: word address width per port
- DEPTH, 1024: total words; multiple of N_BANKS, ≤ 2^ADDR_W
- N_BANKS, 4: bank count, power of 2 (≥1)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- req  in  N_PORTS  per-port access request
- we  in  N_PORTS  per-port write enable (qualified by req)
- addr  in  N_PORTS*ADDR_W  packed addresses, port p at [p*ADDR_W +: ADDR_W]
- wdata  in  N_PORTS*DATA_W  packed write data, same packing
- gnt  out  N_PORTS  combinational grant, access commits on this edge
- rvalid  out  N_PORTS  registered, one-cycle pulse, read data valid
- rdata  out  N_PORTS*DATA_W  registered read data, packed
- oor_err  out  N_PORTS  sticky out-of-range flag per port

## Operation
- Bank mapping: bank = addr mod N_BANKS (low log2(N_BANKS) bits), row = addr / N_BANKS.
- Each bank arbitrates among ports with req=1 targeting it. At most one grant per bank per cycle. Ports on different banks are granted in the same cycle.
- Handshake: master holds req/we/addr/wdata stable until it samples gnt=1. The access commits at that rising edge. Master may drop or change the request the next cycle.
- Write (we=1, granted): bank[row] ← wdata at the grant edge. rvalid is not asserted.
- Read (we=0, granted): rdata[p] registers bank[row] at the grant edge. rvalid[p]=1 for exactly the following cycle. rdata holds its value until the next read grant to that port.
- Out-of-range (addr ≥ DEPTH): arbitrates and is granted normally. Writes are suppressed. A read returns 0 with rvalid=1. oor_err[p] is set and stays set until reset.
- Arbitration policy is selected by the macro (see Configuration). Round-robin: each bank keeps pointer ptr. The search starts at port ptr and ascends modulo N_PORTS. After a grant to port p, ptr ← (p+1) mod N_PORTS. ptr is unchanged when the bank has no grant.
- There is no FSM beyond the per-bank arbitration pointers. Memory contents are not reset.

## Timing
- Reset values (rst_n=0 sampled at an edge): rvalid=0, rdata=0, oor_err=0, all ptr=0. gnt is forced 0 while rst_n=0.
- Grant latency: 0 cycles if uncontended. A contending port waits at most N_PORTS−1 grant cycles on its bank (round-robin).
- Read latency: data valid 1 cycle after the grant edge. Throughput: 1 access/bank/cycle.
- Read-after-write to the same address: write granted at cycle t, read granted at t+1 or later returns the new data. The same bank cannot see both in one cycle.
- Reset asserted mid-operation: pending grants are cancelled and rvalid is cleared on the next edge. No write commits on an edge where rst_n=0.
- A req that is deasserted before gnt is a withdrawn request and has no side effects.

## Configuration
- DMEM_RR_ARB_EN defined: round-robin arbitration per bank as above.
- DMEM_RR_ARB_EN undefined: fixed priority, lowest port index wins. There are no ptr registers, and starvation of high-index ports is permitted.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with all req=1 → gnt=0, rvalid=0, rdata=0, oor_err=0 throughout. Release → grants start the next cycle.
- Parallel no-conflict: ports 0–3 write addr 0,1,2,3 with data 0xA000+p. All gnt=1 in one cycle. Then all read → rvalid=1 one cycle later, rdata=0xA000+p.
- Bank conflict (RR_EN): ports 0,4,8 read addr 0,4,8 (bank 0) continuously → grants in order 0,4,8,0,4,8. Each port gets a grant once every 3 cycles.
- Bank conflict (RR_EN undefined): same stimulus → port 0 is granted every cycle, ports 4 and 8 are never granted.
- Read-after-write: port 2 writes 0x1234 to addr 37 at cycle t, port 5 reads addr 37 at t+1 → rdata[5]=0x1234 at t+2.
- Out-of-range: port 9 writes 0xFFFF to addr 1024, then reads addr 1024 → gnt=1 both times, rdata[9]=0, oor_err[9]=1 and held. Addr 0 is unchanged. oor_err clears only on reset.

Source files
------------

// File: rtl/data_memory_banked.sv
// data_memory_banked: N_PORTS-port word memory over N_BANKS interleaved single-port banks, arbitrated per bank (round-robin when DMEM_RR_ARB_EN is defined, else fixed priority)
module data_memory_banked #(
  parameter int N_PORTS = 10,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 1024,
  parameter int N_BANKS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_PORTS-1:0]        req,
  input  logic [N_PORTS-1:0]        we,
  input  logic [N_PORTS*ADDR_W-1:0] addr,
  input  logic [N_PORTS*DATA_W-1:0] wdata,
  output logic [N_PORTS-1:0]        gnt,
  output logic [N_PORTS-1:0]        rvalid,
  output logic [N_PORTS*DATA_W-1:0] rdata,
  output logic [N_PORTS-1:0]        oor_err
);
  localparam int LB = $clog2(N_BANKS);
  localparam int BW = LB > 0 ? LB : 1;
  localparam int ROWS = DEPTH / N_BANKS;
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int PW = $clog2(N_PORTS);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [BW-1:0]             bk [N_PORTS];
  logic [RW-1:0]             rw [N_PORTS];
  logic [N_PORTS-1:0]        oor;
  logic [N_BANKS-1:0]        found;
  logic [PW-1:0]             sel [N_BANKS];
  logic [PW-1:0]             idx;
  logic [N_BANKS*DATA_W-1:0] rd;
  logic [N_PORTS-1:0]        rvalid_d, rvalid_q, oor_d, oor_q;
  logic [N_PORTS*DATA_W-1:0] rdata_d, rdata_q;

`ifdef DMEM_RR_ARB_EN
  logic [PW-1:0] ptr_d [N_BANKS];
  logic [PW-1:0] ptr_q [N_BANKS];

  // advance each bank's pointer past the port it just granted
  always_comb
    for (int b = 0; b < N_BANKS; b++)
      ptr_d[b] = found[b] ? (sel[b] == PW'(N_PORTS-1) ? '0 : sel[b] + 1'b1) : ptr_q[b];

  // pointer registers
  always_ff @(posedge clk)
    if (!rst_n) for (int b = 0; b < N_BANKS; b++) ptr_q[b] <= '0;
    else ptr_q <= ptr_d;
`endif

  // split each port address into bank, row and out-of-range flag
  always_comb
    for (int p = 0; p < N_PORTS; p++) begin
      bk[p]  = N_BANKS > 1 ? BW'(addr[p*ADDR_W +: ADDR_W]) : '0;
      rw[p]  = RW'(addr[p*ADDR_W +: ADDR_W] >> LB);
      oor[p] = {1'b0, addr[p*ADDR_W +: ADDR_W]} >= DEPTH_L;
    end

  // per-bank winner search; reset suppresses every grant
  always_comb begin
    found = '0;
    idx = '0;
    gnt = '0;
    for (int b = 0; b < N_BANKS; b++) sel[b] = '0;
    for (int b = 0; b < N_BANKS; b++)
      for (int k = 0; k < N_PORTS; k++) begin
`ifdef DMEM_RR_ARB_EN
        idx = PW'((int'(ptr_q[b]) + k) % N_PORTS);
`else
        idx = PW'(k);
`endif
        if (rst_n && req[idx] && int'(bk[idx]) == b && !found[b]) begin
          found[b] = 1'b1;
          sel[b] = idx;
        end
      end
    for (int p = 0; p < N_PORTS; p++) gnt[p] = found[bk[p]] && sel[bk[p]] == PW'(p);
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [ROWS];
    logic              wen;
    assign wen = found[b] && we[sel[b]] && !oor[sel[b]];
    // single write port driven by the bank's granted port
    always_ff @(posedge clk)
      if (wen) mem[rw[sel[b]]] <= wdata[sel[b]*DATA_W +: DATA_W];
    assign rd[b*DATA_W +: DATA_W] = mem[rw[sel[b]]];
  end

  // read capture, valid pulse and sticky range error per port
  always_comb begin
    oor_d = oor_q | (gnt & oor);
    rvalid_d = gnt & ~we;
    rdata_d = rdata_q;
    for (int p = 0; p < N_PORTS; p++)
      if (rvalid_d[p]) rdata_d[p*DATA_W +: DATA_W] = oor[p] ? '0 : rd[bk[p]*DATA_W +: DATA_W];
  end

  // port output registers
  always_ff @(posedge clk)
    if (!rst_n) begin
      rvalid_q <= '0;
      rdata_q <= '0;
      oor_q <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      oor_q <= oor_d;
    end

  assign rvalid = rvalid_q;
  assign rdata = rdata_q;
  assign oor_err = oor_q;
endmodule

// File: tb/tb_data_memory_banked.sv
// tb_data_memory_banked: directed self-checking bench for data_memory_banked
module tb_data_memory_banked;
  localparam int N = 10, DW = 16, AW = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0, we = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0] gnt, rvalid, oor_err;
  logic [N*DW-1:0] rdata;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  data_memory_banked #(.N_PORTS(N), .DATA_W(DW), .ADDR_W(AW), .DEPTH(1024), .N_BANKS(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .oor_err(oor_err)
  );

  task automatic drv(input int p, input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
    req[p] = r;
    we[p] = w;
    addr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic idle();
    req = '0;
    we = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int p = 0; p < N; p++) drv(p, 1, 1, 16'(p), 16'h5500 + 16'(p));
    tick();
    for (int i = 0; i < 3; i++) begin
      total++; if (gnt !== 10'h000) begin bad++; $display("FAIL reset_gnt got=%h exp=000", gnt); end
      total++; if (rvalid !== 10'h000) begin bad++; $display("FAIL reset_rvalid got=%h exp=000", rvalid); end
      total++; if (rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
      total++; if (oor_err !== 10'h000) begin bad++; $display("FAIL reset_oor got=%h exp=000", oor_err); end
      if (i < 2) tick();
    end
    rst_n = 1'b1;
    #1;
    total++; if (gnt !== 10'h00F) begin bad++; $display("FAIL release_gnt got=%h exp=00F", gnt); end
    tick();
    idle();
    total++; if (rvalid !== 10'h000) begin bad++; $display("FAIL release_rvalid got=%h exp=000", rvalid); end
  endtask

  task automatic test_parallel();
    for (int p = 0; p < 4; p++) drv(p, 1, 1, 16'(p), 16'hA000 + 16'(p));
    #1;
    total++; if (gnt !== 10'h00F) begin bad++; $display("FAIL par_wr_gnt got=%h exp=00F", gnt); end
    tick();
    total++; if (rvalid !== 10'h000) begin bad++; $display("FAIL par_wr_rvalid got=%h exp=000", rvalid); end
    for (int p = 0; p < 4; p++) drv(p, 1, 0, 16'(p), 16'h0);
    #1;
    total++; if (gnt !== 10'h00F) begin bad++; $display("FAIL par_rd_gnt got=%h exp=00F", gnt); end
    tick();
    idle();
    total++; if (rvalid !== 10'h00F) begin bad++; $display("FAIL par_rd_rvalid got=%h exp=00F", rvalid); end
    for (int p = 0; p < 4; p++) begin
      total++;
      if (rdata[p*DW +: DW] !== 16'hA000 + 16'(p)) begin
        bad++; $display("FAIL par_rdata port=%0d got=%h exp=%h", p, rdata[p*DW +: DW], 16'hA000 + 16'(p));
      end
    end
    tick();
    total++; if (rvalid !== 10'h000) begin bad++; $display("FAIL par_pulse got=%h exp=000", rvalid); end
    total++; if (rdata[0 +: DW] !== 16'hA000) begin bad++; $display("FAIL par_hold got=%h exp=A000", rdata[0 +: DW]); end
  endtask

  task automatic test_conflict();
    int exp_p [6];
`ifdef DMEM_RR_ARB_EN
    exp_p = '{0, 4, 8, 0, 4, 8};
`else
    exp_p = '{0, 0, 0, 0, 0, 0};
`endif
    drv(9, 1, 0, 16'd0, 16'h0);
    #1;
    total++; if (gnt !== 10'h200) begin bad++; $display("FAIL prime_gnt got=%h exp=200", gnt); end
    tick();
    idle();
    total++; if (rdata[9*DW +: DW] !== 16'hA000) begin bad++; $display("FAIL prime_rdata got=%h exp=A000", rdata[9*DW +: DW]); end
    drv(0, 1, 0, 16'd0, 16'h0);
    drv(4, 1, 0, 16'd4, 16'h0);
    drv(8, 1, 0, 16'd8, 16'h0);
    for (int i = 0; i < 6; i++) begin
      logic [N-1:0] e;
      e = 10'd1 << exp_p[i];
      #1;
      total++; if (gnt !== e) begin bad++; $display("FAIL conflict_gnt cycle=%0d got=%h exp=%h", i, gnt, e); end
      tick();
      total++; if (rvalid !== e) begin bad++; $display("FAIL conflict_rvalid cycle=%0d got=%h exp=%h", i, rvalid, e); end
    end
    idle();
  endtask

  task automatic test_raw();
    drv(2, 1, 1, 16'd37, 16'h1234);
    #1;
    total++; if (gnt !== 10'h004) begin bad++; $display("FAIL raw_wr_gnt got=%h exp=004", gnt); end
    tick();
    idle();
    drv(5, 1, 0, 16'd37, 16'h0);
    #1;
    total++; if (gnt !== 10'h020) begin bad++; $display("FAIL raw_rd_gnt got=%h exp=020", gnt); end
    tick();
    idle();
    total++; if (rvalid !== 10'h020) begin bad++; $display("FAIL raw_rvalid got=%h exp=020", rvalid); end
    total++; if (rdata[5*DW +: DW] !== 16'h1234) begin bad++; $display("FAIL raw_rdata got=%h exp=1234", rdata[5*DW +: DW]); end
  endtask

  task automatic test_oor();
    drv(9, 1, 1, 16'd1024, 16'hFFFF);
    #1;
    total++; if (gnt !== 10'h200) begin bad++; $display("FAIL oor_wr_gnt got=%h exp=200", gnt); end
    tick();
    total++; if (oor_err !== 10'h200) begin bad++; $display("FAIL oor_wr_flag got=%h exp=200", oor_err); end
    total++; if (rvalid !== 10'h000) begin bad++; $display("FAIL oor_wr_rvalid got=%h exp=000", rvalid); end
    drv(9, 1, 0, 16'd1024, 16'h0);
    #1;
    total++; if (gnt !== 10'h200) begin bad++; $display("FAIL oor_rd_gnt got=%h exp=200", gnt); end
    tick();
    idle();
    total++; if (rvalid !== 10'h200) begin bad++; $display("FAIL oor_rd_rvalid got=%h exp=200", rvalid); end
    total++; if (rdata[9*DW +: DW] !== 16'h0000) begin bad++; $display("FAIL oor_rdata got=%h exp=0000", rdata[9*DW +: DW]); end
    drv(0, 1, 0, 16'd0, 16'h0);
    tick();
    idle();
    total++; if (rdata[0 +: DW] !== 16'hA000) begin bad++; $display("FAIL oor_alias got=%h exp=A000", rdata[0 +: DW]); end
    tick();
    tick();
    total++; if (oor_err !== 10'h200) begin bad++; $display("FAIL oor_sticky got=%h exp=200", oor_err); end
  endtask

  task automatic test_reset_mid();
    drv(1, 1, 1, 16'd1, 16'hDEAD);
    drv(9, 1, 0, 16'd0, 16'h0);
    rst_n = 1'b0;
    #1;
    total++; if (gnt !== 10'h000) begin bad++; $display("FAIL mid_gnt got=%h exp=000", gnt); end
    tick();
    total++; if (rvalid !== 10'h000) begin bad++; $display("FAIL mid_rvalid got=%h exp=000", rvalid); end
    total++; if (oor_err !== 10'h000) begin bad++; $display("FAIL mid_oor got=%h exp=000", oor_err); end
    rst_n = 1'b1;
    idle();
    drv(1, 1, 0, 16'd1, 16'h0);
    #1;
    total++; if (gnt !== 10'h002) begin bad++; $display("FAIL mid_rd_gnt got=%h exp=002", gnt); end
    tick();
    idle();
    total++; if (rdata[1*DW +: DW] !== 16'hA001) begin bad++; $display("FAIL mid_nowrite got=%h exp=A001", rdata[1*DW +: DW]); end
  endtask

  initial begin
    test_reset();
    test_parallel();
    test_conflict();
    test_raw();
    test_oor();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
